// File: rtl/bluetooth_packet_tx.sv
// ----------------------------------------------------------------------------
// bluetooth_packet_tx
//
// Frames a payload into a byte packet and shifts it out over a UART line:
//   START_BYTE, LEN, payload[0..LEN-1], CHK, END_BYTE   (LEN+4 bytes)
// CHK is the XOR of LEN and the LEN payload bytes. It is computed once, when
// the request is accepted, from the same inputs that are captured.
//
// Request handshake: req_bluetooth_start is a one-cycle strobe. It is only
// looked at in IDLE. There, a legal length (1..MAX_LEN) is accepted on that
// edge and busy rises the next cycle. An illegal length produces a
// one-cycle error pulse in the next cycle. In every other state the strobe
// is ignored. There is no backpressure beyond busy: a caller waits for
// busy=0 (or the done pulse) before issuing the next request.
//
// Ports:
//   clk                    system clock, rising edge
//   rst                    synchronous active-high reset
//   req_bluetooth_start    packet request strobe
//   req_bluetooth_len      payload byte count
//   req_bluetooth_payload  payload, byte k at [8k+7:8k]
//   req_bluetooth_busy     high from the LOAD of byte 0 through DONE
//   req_bluetooth_done     one-cycle pulse after the final byte's stop bit
//   req_bluetooth_error    one-cycle pulse after a rejected request
//   tx_bluetooth           UART serial line (idle high)
//
// Also contains uart_tx, an 8N1 transmitter with CLKS_PER_BIT clocks per bit.
// ----------------------------------------------------------------------------

module uart_tx #(
   parameter int CLKS_PER_BIT = 16   // 1..65536
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_ready
);
   localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

   // Frame is {stop, data[7:0], start}. The line is the LSB. Ones are
   // shifted in, so the register returns to all-ones (idle) after the
   // stop bit.
   logic [9:0]  shift_q;
   logic [3:0]  bit_cnt;
   logic [15:0] clk_cnt;
   logic        active;

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '1;
         bit_cnt <= '0;
         clk_cnt <= '0;
         active  <= 1'b0;
      end else if (!active) begin
         if (tx_start) begin
            shift_q <= {1'b1, tx_data, 1'b0};
            bit_cnt <= '0;
            clk_cnt <= '0;
            active  <= 1'b1;
         end
      end else if (clk_cnt == LAST_CLK) begin
         clk_cnt <= '0;
         shift_q <= {1'b1, shift_q[9:1]};
         if (bit_cnt == 4'd9) active  <= 1'b0;
         else                 bit_cnt <= bit_cnt + 4'd1;
      end else begin
         clk_cnt <= clk_cnt + 16'd1;
      end
   end

   assign tx       = shift_q[0];
   assign tx_ready = !active;
endmodule

module bluetooth_packet_tx #(
   parameter int         MAX_LEN      = 8,       // 1..255
   parameter logic [7:0] START_BYTE   = 8'hAA,
   parameter logic [7:0] END_BYTE     = 8'h55,
   parameter int         CLKS_PER_BIT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_bluetooth_start,
   input  logic [7:0]             req_bluetooth_len,
   input  logic [8*MAX_LEN-1:0]   req_bluetooth_payload,
   output logic                   req_bluetooth_busy,
   output logic                   req_bluetooth_done,
   output logic                   req_bluetooth_error,
   output logic                   tx_bluetooth
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_SEND = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_WAIT = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

   logic [2:0]             state;
   logic [8:0]             byte_idx;    // 9 bits: LEN+3 reaches 258
   logic [7:0]             len_q;
   logic [7:0]             chk_q;
   logic [8*MAX_LEN-1:0]   payload_q;
   logic [7:0]             tx_data;
   logic                   tx_start;
   logic                   tx_ready;
   logic                   error_q;

   logic                   len_ok;
   logic                   accept;
   logic                   reject;
   logic [7:0]             chk_next;
   logic [7:0]             cur_byte;
   logic [8:0]             last_idx;
   logic [8:0]             chk_idx;

   assign len_ok = (req_bluetooth_len != 8'd0) && (req_bluetooth_len <= MAX_LEN8);
   assign accept = (state == S_IDLE) && req_bluetooth_start &&  len_ok;
   assign reject = (state == S_IDLE) && req_bluetooth_start && !len_ok;

   assign last_idx = {1'b0, len_q} + 9'd3;
   assign chk_idx  = {1'b0, len_q} + 9'd2;

   // Checksum over the request as presented, so it is ready long before
   // the CHK byte is loaded.
   always_comb begin
      chk_next = req_bluetooth_len;
      for (int k = 0; k < MAX_LEN; k++)
         if (9'(k) < {1'b0, req_bluetooth_len})
            chk_next = chk_next ^ req_bluetooth_payload[8*k +: 8];
   end

   // Byte selection. The framing bytes take priority over payload slots
   // beyond LEN that alias the CHK/END positions.
   always_comb begin
      cur_byte = 8'h00;
      for (int k = 0; k < MAX_LEN; k++)
         if (byte_idx == 9'(k + 2)) cur_byte = payload_q[8*k +: 8];
      if (byte_idx == 9'd0)          cur_byte = START_BYTE;
      else if (byte_idx == 9'd1)     cur_byte = len_q;
      else if (byte_idx == chk_idx)  cur_byte = chk_q;
      else if (byte_idx == last_idx) cur_byte = END_BYTE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         byte_idx  <= '0;
         len_q     <= '0;
         chk_q     <= '0;
         payload_q <= '0;
         tx_data   <= '0;
         error_q   <= 1'b0;
      end else begin
         error_q <= 1'b0;
         case (state)
            S_IDLE: begin
               error_q <= reject;
               if (accept) begin
                  len_q     <= req_bluetooth_len;
                  payload_q <= req_bluetooth_payload;
                  chk_q     <= chk_next;
                  byte_idx  <= '0;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_data <= cur_byte;
               state   <= S_SEND;
            end
            S_SEND: state <= S_HOLD;
            // The UART registers tx_start on the SEND edge. Waiting one
            // more cycle guarantees tx_ready already shows the new byte.
            S_HOLD: state <= S_WAIT;
            S_WAIT: begin
               if (tx_ready) begin
                  if (byte_idx == last_idx) begin
                     state <= S_DONE;
                  end else begin
                     byte_idx <= byte_idx + 9'd1;
                     state    <= S_LOAD;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign tx_start            = (state == S_SEND);
   assign req_bluetooth_busy  = (state != S_IDLE);
   assign req_bluetooth_done  = (state == S_DONE);
   assign req_bluetooth_error = error_q;

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx       (tx_bluetooth),
      .tx_ready (tx_ready)
   );
endmodule

// File: tb/tb_bluetooth_packet_tx.sv
// ----------------------------------------------------------------------------
// tb_bluetooth_packet_tx
//
// Bench for bluetooth_packet_tx. An independent UART receiver decodes the
// serial line into a byte queue. The expected packets are built from the
// packet framing rules: start, len, payload, XOR checksum, end.
// ----------------------------------------------------------------------------

module tb_bluetooth_packet_tx;
   localparam int MAX_LEN = 8;
   localparam int CPB     = 4;
   localparam int SAMPLE  = CPB / 2;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                 req_start;
   logic [7:0]           req_len;
   logic [8*MAX_LEN-1:0] req_payload;
   logic                 busy;
   logic                 done;
   logic                 error;
   logic                 tx_line;

   bluetooth_packet_tx #(
      .MAX_LEN      (MAX_LEN),
      .START_BYTE   (8'hAA),
      .END_BYTE     (8'h55),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_bluetooth_start   (req_start),
      .req_bluetooth_len     (req_len),
      .req_bluetooth_payload (req_payload),
      .req_bluetooth_busy    (busy),
      .req_bluetooth_done    (done),
      .req_bluetooth_error   (error),
      .tx_bluetooth          (tx_line)
   );

   int compared   = 0;
   int mismatched = 0;

   // Observed-side state, written only by the monitor process.
   logic [7:0] rx_q[$];
   int done_cnt      = 0;
   int err_cnt       = 0;
   int start_cnt     = 0;
   int bad_start_cnt = 0;
   int frame_err_cnt = 0;

   // Monitor and UART receiver, sampling on the falling edge.
   initial begin : monitor
      bit         rx_active;
      int         rx_cnt;
      int         j;
      logic [7:0] rx_byte;
      rx_active = 1'b0;
      rx_cnt    = 0;
      rx_byte   = 8'h00;
      forever begin
         @(negedge clk);
         if (done === 1'b1)  done_cnt++;
         if (error === 1'b1) err_cnt++;
         if (dut.tx_start === 1'b1) begin
            start_cnt++;
            if (dut.tx_ready !== 1'b1) bad_start_cnt++;
         end
         if (rst === 1'b1) begin
            rx_active = 1'b0;
         end else if (!rx_active) begin
            if (tx_line === 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt >= SAMPLE && ((rx_cnt - SAMPLE) % CPB) == 0) begin
               j = (rx_cnt - SAMPLE) / CPB;
               if (j == 0) begin
                  if (tx_line !== 1'b0) frame_err_cnt++;
               end else if (j <= 8) begin
                  rx_byte[j-1] = tx_line;
               end else begin
                  if (tx_line !== 1'b1) frame_err_cnt++;
                  rx_q.push_back(rx_byte);
                  rx_active = 1'b0;
               end
            end
         end
      end
   end

   // One cycle, landing just after the falling edge so the monitor has
   // already run for that edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Drives one request and checks the whole packet against the reference
   // framing. spam keeps the strobe high (with junk lengths) for the whole
   // packet. chain returns on the done cycle so the caller can issue the
   // next request in the first IDLE cycle.
   task automatic run_packet(input int len, input logic [63:0] pay,
                             input bit spam, input bit chain, input string tag);
      logic [7:0] exp_q[$];
      logic [7:0] chk;
      int base_rx, base_start, base_done, base_err;
      bit busy_ok, got_done;
      exp_q = {};
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'(len));
      chk = 8'(len);
      for (int k = 0; k < len; k++) begin
         exp_q.push_back(pay[8*k +: 8]);
         chk = chk ^ pay[8*k +: 8];
      end
      exp_q.push_back(chk);
      exp_q.push_back(8'h55);

      base_rx    = rx_q.size();
      base_start = start_cnt;
      base_done  = done_cnt;
      base_err   = err_cnt;
      busy_ok    = 1'b1;
      got_done   = 1'b0;

      step();
      req_start   = 1'b1;
      req_len     = 8'(len);
      req_payload = pay;

      // LOAD cycle: busy, no tx_start yet. Inputs are scrambled to show
      // they were captured.
      step();
      if (!spam) req_start = 1'b0;
      req_len     = 8'($urandom_range(0, 255));
      req_payload = {$urandom, $urandom};
      compared++;
      if (busy !== 1'b1 || dut.tx_start !== 1'b0) begin
         mismatched++;
         $display("FAIL %s load_cycle: busy=%b tx_start=%b, need busy=1 tx_start=0",
                  tag, busy, dut.tx_start);
      end

      // SEND cycle: first tx_start two cycles after acceptance.
      step();
      compared++;
      if (dut.tx_start !== 1'b1) begin
         mismatched++;
         $display("FAIL %s first_start_latency: tx_start=%b, need 1", tag, dut.tx_start);
      end

      for (int c = 0; c < 4000; c++) begin
         step();
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            got_done = 1'b1;
            break;
         end
         if (spam) req_len = 8'($urandom_range(0, 255));
      end
      compared++;
      if (!got_done) begin
         mismatched++;
         $display("FAIL %s done_timeout: no done within 4000 cycles", tag);
      end

      if (!chain) begin
         step();
         req_start = 1'b0;
         compared++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL %s after_done: busy=%b done=%b, need 0 0", tag, busy, done);
         end
      end

      compared++;
      if (rx_q.size() - base_rx != exp_q.size()) begin
         mismatched++;
         $display("FAIL %s byte_count: got %0d bytes, need %0d",
                  tag, rx_q.size() - base_rx, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base_rx + i < rx_q.size()) begin
            compared++;
            if (rx_q[base_rx + i] !== exp_q[i]) begin
               mismatched++;
               $display("FAIL %s byte[%0d]: got %02h, need %02h",
                        tag, i, rx_q[base_rx + i], exp_q[i]);
            end
         end
      end
      compared++;
      if (start_cnt - base_start != len + 4) begin
         mismatched++;
         $display("FAIL %s start_pulses: got %0d, need %0d", tag, start_cnt - base_start, len + 4);
      end
      compared++;
      if (done_cnt - base_done != 1) begin
         mismatched++;
         $display("FAIL %s done_pulses: got %0d, need 1", tag, done_cnt - base_done);
      end
      compared++;
      if (err_cnt - base_err != 0) begin
         mismatched++;
         $display("FAIL %s error_pulses: got %0d, need 0", tag, err_cnt - base_err);
      end
      compared++;
      if (!busy_ok) begin
         mismatched++;
         $display("FAIL %s busy_throughout: busy dropped, need held 1", tag);
      end
      compared++;
      if (bad_start_cnt != 0 || frame_err_cnt != 0) begin
         mismatched++;
         $display("FAIL %s line_integrity: start_while_busy=%0d frame_errors=%0d, need 0 0",
                  tag, bad_start_cnt, frame_err_cnt);
      end
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      req_start   = 1'b1;   // must not be accepted while in reset
      req_len     = 8'd3;
      req_payload = {$urandom, $urandom};
      repeat (3) step();
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || dut.tx_start !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: busy=%b done=%b error=%b tx_start=%b, need 0",
                  busy, done, error, dut.tx_start);
      end
      compared++;
      if (tx_line !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_line: tx=%b, need 1", tx_line);
      end
      compared++;
      if (dut.byte_idx !== 9'd0 || dut.len_q !== 8'd0 || dut.chk_q !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_regs: idx=%0h len=%0h chk=%0h, need 0",
                  dut.byte_idx, dut.len_q, dut.chk_q);
      end
      req_start = 1'b0;
      rst       = 1'b0;
      step();
      compared++;
      if (busy !== 1'b0 || error !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_release: busy=%b error=%b, need 0 0", busy, error);
      end
   endtask

   task automatic test_directed_len3();
      run_packet(3, 64'h0000_0000_0003_0201, 1'b0, 1'b0, "len3");
   endtask

   task automatic test_max_len();
      run_packet(MAX_LEN, 64'h1716_1514_1312_1110, 1'b0, 1'b0, "max_len");
   endtask

   task automatic test_errors();
      int lens[3];
      int base_err, base_start, base_rx;
      lens[0] = 0;
      lens[1] = MAX_LEN + 1;
      lens[2] = $urandom_range(MAX_LEN + 1, 255);
      for (int i = 0; i < 3; i++) begin
         base_err   = err_cnt;
         base_start = start_cnt;
         base_rx    = rx_q.size();
         step();
         req_start   = 1'b1;
         req_len     = 8'(lens[i]);
         req_payload = {$urandom, $urandom};
         step();
         req_start = 1'b0;
         compared++;
         if (error !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reject_len%0d pulse: error=%b busy=%b, need 1 0", lens[i], error, busy);
         end
         step();
         compared++;
         if (error !== 1'b0 || busy !== 1'b0 || tx_line !== 1'b1) begin
            mismatched++;
            $display("FAIL reject_len%0d after: error=%b busy=%b tx=%b, need 0 0 1",
                     lens[i], error, busy, tx_line);
         end
         repeat (8) step();
         compared++;
         if (err_cnt - base_err != 1 || start_cnt != base_start || rx_q.size() != base_rx) begin
            mismatched++;
            $display("FAIL reject_len%0d counts: errors=%0d starts=%0d bytes=%0d, need 1 0 0",
                     lens[i], err_cnt - base_err, start_cnt - base_start, rx_q.size() - base_rx);
         end
      end
   endtask

   task automatic test_start_ignored();
      run_packet(2, {$urandom, $urandom}, 1'b1, 1'b0, "start_spam");
   endtask

   task automatic test_reset_mid_packet();
      int  base_start, base_done;
      bit  line_low, reached;
      base_start = start_cnt;
      base_done  = done_cnt;
      reached    = 1'b0;
      step();
      req_start   = 1'b1;
      req_len     = 8'd4;
      req_payload = {$urandom, $urandom};
      step();
      req_start = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (start_cnt - base_start >= 3) begin
            reached = 1'b1;
            break;
         end
         step();
      end
      compared++;
      if (!reached) begin
         mismatched++;
         $display("FAIL abort_third_byte: only %0d tx_start pulses seen, need 3",
                  start_cnt - base_start);
      end
      repeat (CPB * 3) step();   // in the middle of the 3rd byte
      rst = 1'b1;
      step();
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || tx_line !== 1'b1) begin
         mismatched++;
         $display("FAIL abort_in_reset: busy=%b done=%b tx=%b, need 0 0 1", busy, done, tx_line);
      end
      step();
      rst      = 1'b0;
      line_low = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (tx_line !== 1'b1 || busy !== 1'b0) line_low = 1'b1;
      end
      compared++;
      if (line_low || done_cnt != base_done || start_cnt - base_start != 3) begin
         mismatched++;
         $display("FAIL abort_quiet: activity=%b done=%0d starts=%0d, need 0 0 3",
                  line_low, done_cnt - base_done, start_cnt - base_start);
      end
      run_packet(1, 64'h0, 1'b0, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      run_packet($urandom_range(1, MAX_LEN), {$urandom, $urandom}, 1'b0, 1'b1, "b2b_first");
      run_packet($urandom_range(1, MAX_LEN), {$urandom, $urandom}, 1'b0, 1'b0, "b2b_second");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         run_packet($urandom_range(1, MAX_LEN), {$urandom, $urandom}, 1'b0, 1'b0, "random");
   endtask

   initial begin
      rst         = 1'b1;
      req_start   = 1'b0;
      req_len     = 8'd0;
      req_payload = '0;
      test_reset();
      test_directed_len3();
      test_max_len();
      test_errors();
      test_start_ignored();
      test_reset_mid_packet();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/bluetooth_packet_tx.md
BLUETOOTH_PACKET_TX -- requirements
Module: bluetooth_packet_tx

Interface
REQ-001 Parameter MAX_LEN, default 8, meaning maximum payload bytes per packet (range 1..255).
REQ-002 Parameter START_BYTE, default 8'hAA, meaning the packet's first byte.
REQ-003 Parameter END_BYTE, default 8'h55, meaning the packet's last byte.
REQ-004 clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  meaning the reset, synchronous and active-high.
REQ-006 req_bluetooth_start  input  1  meaning a one-cycle packet request strobe.
REQ-007 req_bluetooth_len  input  8  meaning the payload byte count for this request.
REQ-008 req_bluetooth_payload  input  8*MAX_LEN  meaning the payload bytes, with byte k at bits [8k+7:8k].
REQ-009 req_bluetooth_busy  output  1  meaning high from acceptance until the done pulse, inclusive.
REQ-010 req_bluetooth_done  output  1  meaning a one-cycle pulse when the packet's final byte has completed.
REQ-011 req_bluetooth_error  output  1  meaning a one-cycle pulse when a request is rejected.
REQ-012 tx_bluetooth  output  1  meaning the UART serial line, driven by an internal uart_tx instance (tx_start, tx_data, tx, tx_ready).

Function
REQ-013 Packet byte order shall be: START_BYTE, LEN, payload[0..LEN-1], CHK, END_BYTE, for a total of LEN+4 bytes.
REQ-014 CHK shall be the 8-bit XOR of LEN and all LEN payload bytes.
- START_BYTE and END_BYTE are excluded from CHK.
- Example: LEN=1, payload 0x00 gives CHK=0x01.
REQ-015 A request shall be accepted only in IDLE, when req_bluetooth_start=1 and 1<=req_bluetooth_len<=MAX_LEN.
REQ-016 On acceptance, len and the full payload vector shall be captured into internal registers.
- Input changes after acceptance have no effect on the packet.
REQ-017 In IDLE, req_bluetooth_start=1 with len=0 or len>MAX_LEN shall be rejected.
- req_bluetooth_error pulses for exactly one cycle, in the next cycle.
- No byte is transmitted.
- State stays IDLE and busy stays 0.
REQ-018 req_bluetooth_start outside IDLE (including during DONE) shall be ignored.
- No error pulse.
- The packet in flight is unaffected.
REQ-019 FSM states are IDLE, LOAD, SEND, HOLD, WAIT, DONE. Transitions:
- IDLE->LOAD on acceptance.
- LOAD->SEND unconditionally.
- SEND->HOLD unconditionally.
- HOLD->WAIT unconditionally.
- WAIT->LOAD when tx_ready=1 and the byte is not the last.
- WAIT->DONE when tx_ready=1 and the byte is the last.
- DONE->IDLE unconditionally.
REQ-020 LOAD shall register the current byte, selected by byte index 0..LEN+3, into the uart_tx data register.
REQ-021 SEND shall assert uart_tx tx_start for exactly one cycle, with tx_data stable from that cycle until WAIT exits.
REQ-022 HOLD is a one-cycle guard so that the sampled tx_ready reflects the started byte.
REQ-023 WAIT shall hold until tx_ready=1, then increment the byte index.
REQ-024 Exactly one tx_start pulse shall occur per packet byte, i.e. LEN+4 pulses per packet, with none while tx_ready=0.
REQ-025 CHK shall accumulate during transmission of the LEN and payload bytes, or be computed at acceptance; it shall be valid by the LOAD of its byte.
REQ-026 Byte-index and length arithmetic shall use 9 bits so that LEN+3 does not wrap at LEN=255.
REQ-027 req_bluetooth_done shall be high only in DONE.
REQ-028 req_bluetooth_busy shall be high in LOAD, SEND, HOLD, WAIT and DONE.
REQ-029 Acceptance-to-first-tx_start latency shall be 2 cycles: accept edge, then LOAD, then SEND.
REQ-030 Back-to-back packets are permitted: a new start in the first IDLE cycle after DONE shall be accepted.

Reset
REQ-031 While rst=1, the FSM shall enter IDLE and outputs shall be: busy=0, done=0, error=0, tx_start=0.
REQ-032 While rst=1, the byte index, captured length and CHK shall be 0.
REQ-033 While rst=1, tx_bluetooth shall be 1 (line idle) via uart_tx reset.
REQ-034 Reset mid-packet shall abort the packet:
- No done pulse.
- The remaining bytes are never sent.
- The first cycle after rst deassertion is IDLE and accepts requests.

Verification
REQ-035 len=3, payload 0x01,0x02,0x03 -> UART bytes AA 03 01 02 03 03 55; one done pulse; busy high throughout.
REQ-036 len=MAX_LEN=8, payload 0x10..0x17 -> 12 bytes ending CHK=0x08, 55; exactly 12 tx_start pulses.
REQ-037 len=0, then len=9 -> error pulse each time, one cycle later; tx_bluetooth held 1; busy stays 0.
REQ-038 start asserted every cycle during a len=2 packet -> exactly one packet of 6 bytes; no error pulse; done pulses once.
REQ-039 rst asserted during the 3rd byte of a len=4 packet -> busy=0, no done pulse, line idle; the next len=1 request (payload 0x00) sends AA 01 00 01 55.
REQ-040 done cycle followed by start in the next cycle -> second packet's first tx_start 2 cycles after acceptance; both packets bit-exact.
